// File: rtl/sfi_pkg.sv
// Shared types and default widths for the software-fault-isolation address guard.
package sfi_pkg;

  localparam int SFI_ADDR_W = 64;
  localparam int SFI_TAG_W  = 8;

  typedef enum logic [1:0] {
    SFI_ZERO  = 2'd0,
    SFI_FORCE = 2'd1,
    SFI_DROP  = 2'd2,
    SFI_RSVD  = 2'd3
  } sfi_mode_e;

  typedef struct packed {
    logic [SFI_TAG_W-1:0] tag;
    logic                 en;
  } region_t;

endpackage

// File: rtl/sfi_region_table.sv
// Sandbox region table: programmable tag/enable entries with a combinational
// any-enabled-entry match and the region-0 tag used for FORCE remapping.
module sfi_region_table
  import sfi_pkg::*;
#(
  parameter int               TAG_W       = SFI_TAG_W,
  parameter int               NUM_REGIONS = 4,
  parameter int               IDX_W       = 2,
  parameter logic [TAG_W-1:0] RST_TAG     = 8'hA2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [TAG_W-1:0] cfg_tag,
  input  logic             cfg_en,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             match,
  output logic [TAG_W-1:0] entry0_tag
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             en;
  } entry_t;

  entry_t entries [NUM_REGIONS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        entries[i] <= '{tag: '0, en: 1'b0};
      end
      entries[0] <= '{tag: RST_TAG, en: 1'b1};
    end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      entries[cfg_idx] <= '{tag: cfg_tag, en: cfg_en};
    end
  end

  // Lookup sees the pre-write contents when a write lands in the same cycle.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (entries[i].en && (entries[i].tag == lookup_tag)) match = 1'b1;
    end
  end

  assign entry0_tag = entries[0].tag;

endmodule

// File: rtl/sfi_guard_pipe.sv
// Two-stage valid/ready address guard: S1 captures the beat and its region match,
// S2 holds the guarded result; violations update sticky fault and a saturating count.
module sfi_guard_pipe
  import sfi_pkg::*;
#(
  parameter int                ADDR_W      = SFI_ADDR_W,
  parameter int                TAG_W       = SFI_TAG_W,
  parameter int                NUM_REGIONS = 4,
  parameter int                CNT_W       = 16,
  parameter logic [TAG_W-1:0]  RST_TAG     = 8'hA2,
  localparam int               IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_viol,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [TAG_W-1:0]  cfg_tag,
  input  logic              cfg_en,
  output logic              fault,
  input  logic              fault_clr,
  output logic [CNT_W-1:0]  viol_cnt
);

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  sfi_mode_e         mode_p1;
  logic              match_p1;

  logic              lookup_match;
  logic [TAG_W-1:0]  entry0_tag;
  logic              drop_p1;
  logic              adv_p1;
  logic              fire_p1;
  logic              commit;

  function automatic logic [ADDR_W-1:0] guard_addr(input logic [ADDR_W-1:0] addr,
                                                   input sfi_mode_e         m,
                                                   input logic              hit,
                                                   input logic [TAG_W-1:0]  tag0);
    if (hit)                   return addr;
    else if (m == SFI_FORCE)   return {tag0, addr[ADDR_W-TAG_W-1:0]};
    else                       return '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  sfi_region_table #(
    .TAG_W      (TAG_W),
    .NUM_REGIONS(NUM_REGIONS),
    .IDX_W      (IDX_W),
    .RST_TAG    (RST_TAG)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_tag   (cfg_tag),
    .cfg_en    (cfg_en),
    .lookup_tag(in_addr[ADDR_W-1 -: TAG_W]),
    .match     (lookup_match),
    .entry0_tag(entry0_tag)
  );

  // A DROP miss never needs S2, so it may leave S1 even while S2 is stalled.
  assign drop_p1  = vld_p1 && !match_p1 && (mode_p1 == SFI_DROP);
  assign adv_p1   = !out_valid || out_ready || drop_p1;
  assign fire_p1  = vld_p1 && adv_p1;
  assign commit   = fire_p1 && !match_p1;
  assign in_ready = rst_n && (!vld_p1 || adv_p1);

  // Stage 1: capture beat and region lookup
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1 <= 1'b1;
    end else if (adv_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      addr_p1  <= in_addr;
      mode_p1  <= sfi_mode_e'(mode);
      match_p1 <= lookup_match;
    end
  end

  // Stage 2: apply action and hold output until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_viol  <= 1'b0;
    end else if (fire_p1 && !drop_p1) begin
      out_valid <= 1'b1;
      out_addr  <= guard_addr(addr_p1, mode_p1, match_p1, entry0_tag);
      out_viol  <= !match_p1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A commit in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      viol_cnt <= '0;
    end else if (commit) begin
      fault    <= 1'b1;
      viol_cnt <= fault_clr ? {{(CNT_W-1){1'b0}}, 1'b1} : sat_inc(viol_cnt);
    end else if (fault_clr) begin
      fault    <= 1'b0;
      viol_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sfi_guard_pipe.sv
// Directed bench for sfi_guard_pipe with 32-bit addresses and a 3-bit counter.
module tb_sfi_guard_pipe;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 8;
  localparam int NREG   = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [1:0]        mode = 2'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic              out_viol;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic [TAG_W-1:0]  cfg_tag = '0;
  logic              cfg_en = 1'b0;
  logic              fault;
  logic              fault_clr = 1'b0;
  logic [CNT_W-1:0]  viol_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [ADDR_W-1:0] got_a[$], exp_a[$];
  logic              got_v[$], exp_v[$];
  int                got_c[$];

  sfi_guard_pipe #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_REGIONS(NREG), .CNT_W(CNT_W), .RST_TAG(8'hA2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_viol(out_viol), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tag(cfg_tag),
    .cfg_en(cfg_en), .fault(fault), .fault_clr(fault_clr), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot at negedge: inputs only change just after posedge, so this is what the next edge transfers.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_a.push_back(out_addr);
      got_v.push_back(out_viol);
      got_c.push_back(cyc + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_beat(input logic [ADDR_W-1:0] a, input logic v);
    exp_a.push_back(a);
    exp_v.push_back(v);
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [1:0] m, output int acyc);
    int  budget;
    logic acc;
    budget = 0;
    in_valid = 1'b1;
    in_addr  = a;
    mode     = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    acyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [TAG_W-1:0] tag, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_tag = tag; cfg_en = en;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    int n;
    budget = 0;
    while (got_a.size() < exp_a.size() && budget < 40) begin
      tick(1);
      budget++;
    end
    tick(4);
    chk({name, "_count"}, 64'(got_a.size()), 64'(exp_a.size()));
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", name, i), 64'(got_a[i]), 64'(exp_a[i]));
      chk($sformatf("%s_viol%0d", name, i), 64'(got_v[i]), 64'(exp_v[i]));
    end
    got_a.delete(); got_v.delete(); got_c.delete();
    exp_a.delete(); exp_v.delete();
  endtask

  initial begin
    int a0, a1, a2;
    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cnt", 64'(viol_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // 1: ZERO mode miss then hit, with latency
    send(32'h00FFEEDD, 2'd0, a0);
    send(32'hA2199872, 2'd0, a1);
    expect_beat(32'h0, 1'b1);
    expect_beat(32'hA2199872, 1'b0);
    tick(4);
    if (got_c.size() >= 2) begin
      chk("t1_lat0", 64'(got_c[0] - a0), 64'd2);
      chk("t1_lat1", 64'(got_c[1] - a1), 64'd2);
    end
    drain("t1");
    chk("t1_fault", 64'(fault), 64'd1);
    chk("t1_cnt", 64'(viol_cnt), 64'd1);

    // 2: FORCE remaps tag to region 0
    send(32'h00FFEEDD, 2'd1, a0);
    expect_beat(32'hA2FFEEDD, 1'b1);
    drain("t2");
    chk("t2_cnt", 64'(viol_cnt), 64'd2);

    // 3: DROP removes the miss without stalling input
    send(32'hA2000001, 2'd2, a0);
    send(32'h11000002, 2'd2, a1);
    send(32'hA2000003, 2'd2, a2);
    chk("t3_no_bubble", 64'(a2 - a0), 64'd2);
    expect_beat(32'hA2000001, 1'b0);
    expect_beat(32'hA2000003, 1'b0);
    drain("t3");
    chk("t3_cnt", 64'(viol_cnt), 64'd3);

    // 4: same-cycle write uses old table; later beat sees new entry
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_tag = 8'h11; cfg_en = 1'b1;
    send(32'h11000005, 2'd0, a0);
    cfg_we = 1'b0;
    send(32'h11000002, 2'd0, a1);
    expect_beat(32'h0, 1'b1);
    expect_beat(32'h11000002, 1'b0);
    drain("t4");
    chk("t4_cnt", 64'(viol_cnt), 64'd4);

    // 5: backpressure during a 4-beat burst
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(32'hA2000010 + 32'(i), 2'd0, a0);
          expect_beat(32'hA2000010 + 32'(i), 1'b0);
        end
      end
      begin
        tick(3);
        chk("t5_stall_ready", 64'(in_ready), 64'd0);
        chk("t5_stall_valid", 64'(out_valid), 64'd1);
        chk("t5_hold_a", 64'(out_addr), 64'hA2000010);
        tick(2);
        chk("t5_hold_b", 64'(out_addr), 64'hA2000010);
        chk("t5_still_blocked", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain("t5");

    // 6a: clear coincident with commit, then plain clear
    send(32'h33000000, 2'd0, a0);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("t6_fault", 64'(fault), 64'd1);
    chk("t6_cnt", 64'(viol_cnt), 64'd1);
    expect_beat(32'h0, 1'b1);
    drain("t6a");
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_fault", 64'(fault), 64'd0);
    chk("clr_cnt", 64'(viol_cnt), 64'd0);

    // Counter saturation
    for (int i = 0; i < 9; i++) send(32'h44000000 + 32'(i), 2'd2, a0);
    tick(3);
    chk("sat_cnt", 64'(viol_cnt), 64'd7);
    chk("sat_fault", 64'(fault), 64'd1);
    drain("sat");

    // All entries disabled; FORCE still uses entry0 tag
    cfg_write(2'd0, 8'h5A, 1'b0);
    cfg_write(2'd2, 8'h11, 1'b0);
    send(32'hA2000020, 2'd1, a0);
    send(32'h5A000021, 2'd3, a1);
    expect_beat(32'h5A000020, 1'b1);
    expect_beat(32'h0, 1'b1);
    drain("dis");

    // 6b: reset with beats in flight
    out_ready = 1'b0;
    send(32'hA2000040, 2'd0, a0);
    send(32'h5A000041, 2'd0, a1);
    rst_n = 1'b0;
    tick(1);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd0);
    chk("rst2_cnt", 64'(viol_cnt), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(6);
    drain("rst2_flush");
    send(32'hA2000030, 2'd0, a0);
    send(32'h11000031, 2'd0, a1);
    expect_beat(32'hA2000030, 1'b0);
    expect_beat(32'h0, 1'b1);
    drain("rst2_table");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
